// File: rtl/disc_reader_if.sv
// Bus bundle for disc_reader: raw drive inputs, acquisition control and capture-memory outputs.
// master = block driving the controls (host/bench), slave = the disc_reader itself.
interface disc_reader_if;
    logic       rddata;
    logic       index;
    logic       trkmark;
    logic       start;
    logic       abort;
    logic [1:0] sync_mode;
    logic [5:0] stop_idx;
    logic       mem_full;
    logic [7:0] mdat_out;
    logic       mwrite;
    logic       maddr_inc;
    logic       running;
    logic       overflow;

    modport master (
        output rddata, index, trkmark, start, abort, sync_mode, stop_idx, mem_full,
        input  mdat_out, mwrite, maddr_inc, running, overflow
    );

    modport slave (
        input  rddata, index, trkmark, start, abort, sync_mode, stop_idx, mem_full,
        output mdat_out, mwrite, maddr_inc, running, overflow
    );
endinterface

// File: rtl/disc_reader.sv
// Flux-interval disc reader: times flux transitions into 7-bit counts and streams them to capture memory.
// Optional hard-sector track-mark arming is built only when DISC_READER_HSTMD_SYNC_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start; outputs quiet
// S_ARM  | waiting for the selected sync condition (immediate / index / track mark)
// S_ACQ  | counting intervals and writing one byte per flux event or counter carry
module disc_reader (
    input  logic         clock,
    input  logic         reset,
    disc_reader_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_ACQ  = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_rd_sync;
    logic [2:0] r_idx_sync;
    logic [1:0] r_mode;
    logic       r_stop_en;
    logic [5:0] r_idx_cnt;
    logic [6:0] r_cnt;
    logic       r_flag;
    logic [7:0] r_mdat;
    logic       r_mwrite;
    logic       r_maddr_inc;
    logic       r_running;
    logic       r_overflow;

    logic       w_flux;
    logic       w_idx_evt;
    logic       w_arm_go;
    logic       w_stop_hit;
    logic       w_carry;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_sync  <= 3'b000;
            r_idx_sync <= 3'b000;
        end else begin
            r_rd_sync  <= {r_rd_sync[1:0], bus.rddata};
            r_idx_sync <= {r_idx_sync[1:0], bus.index};
        end
    end

    // rddata is an active-low pulse: the event is the falling edge seen between the last two stages
    assign w_flux    = r_rd_sync[2] & ~r_rd_sync[1];
    assign w_idx_evt = r_idx_sync[1] & ~r_idx_sync[2];

`ifdef DISC_READER_HSTMD_SYNC_EN
    logic [1:0] r_trk_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_trk_sync <= 2'b00;
        end else begin
            r_trk_sync <= {r_trk_sync[0], bus.trkmark};
        end
    end

    always_comb begin
        w_arm_go = 1'b1;
        unique case (r_mode)
            2'b01:   w_arm_go = w_idx_evt;
            2'b10:   w_arm_go = r_trk_sync[1];
            default: w_arm_go = 1'b1;
        endcase
    end
`else
    logic w_unused_trk;
    assign w_unused_trk = bus.trkmark;

    always_comb begin
        w_arm_go = 1'b1;
        if (r_mode == 2'b01) begin
            w_arm_go = w_idx_evt;
        end
    end
`endif

    // A zero count on ACQ entry means the arming index already used up a stop count of one
    assign w_stop_hit = r_stop_en & ((w_idx_evt & (r_idx_cnt == 6'd1)) | (r_idx_cnt == 6'd0));
    assign w_carry    = (r_cnt == 7'd127);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'b00;
            r_stop_en   <= 1'b0;
            r_idx_cnt   <= 6'd0;
            r_cnt       <= 7'd0;
            r_flag      <= 1'b0;
            r_mdat      <= 8'h00;
            r_mwrite    <= 1'b0;
            r_maddr_inc <= 1'b0;
            r_running   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_mwrite    <= 1'b0;
            r_maddr_inc <= r_mwrite;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state    <= S_ARM;
                        r_running  <= 1'b1;
                        r_mode     <= bus.sync_mode;
                        r_stop_en  <= |bus.stop_idx;
                        r_idx_cnt  <= bus.stop_idx;
                        r_overflow <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end else if (w_arm_go) begin
                        r_state <= S_ACQ;
                        r_cnt   <= 7'd1;
                        r_flag  <= 1'b0;
                        if (r_mode == 2'b01 && r_stop_en) begin
                            r_idx_cnt <= r_idx_cnt - 6'd1;
                        end
                    end
                end
                S_ACQ: begin
                    if (bus.abort) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end else if (bus.mem_full) begin
                        r_state    <= S_IDLE;
                        r_running  <= 1'b0;
                        r_overflow <= 1'b1;
                    end else if (w_stop_hit) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_mwrite  <= 1'b1;
                        r_mdat    <= {1'b1, r_cnt};
                    end else begin
                        if (w_idx_evt && r_stop_en) begin
                            r_idx_cnt <= r_idx_cnt - 6'd1;
                        end
                        // A carry byte of 0 tells the decoder to add 127 to the next interval
                        if (w_flux || w_carry) begin
                            r_mwrite <= 1'b1;
                            r_mdat   <= {r_flag | w_idx_evt, w_flux ? r_cnt : 7'h00};
                            r_cnt    <= 7'd1;
                            r_flag   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                            if (w_idx_evt) begin
                                r_flag <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mdat_out  = r_mdat;
    assign bus.mwrite    = r_mwrite;
    assign bus.maddr_inc = r_maddr_inc;
    assign bus.running   = r_running;
    assign bus.overflow  = r_overflow;
endmodule

// File: doc/disc_reader.md
DISC_READER -- requirements
Module: disc_reader

Interface
REQ-001 SHALL have port: clock  in  1  master clock; all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-003 SHALL have port: rddata  in  1  raw drive read data, asynchronous, active-low flux pulse.
REQ-004 SHALL have port: index  in  1  index pulse, asynchronous, active-high.
REQ-005 SHALL have port: trkmark  in  1  hard-sector track-mark detect, level.
REQ-006 SHALL have port: start  in  1  begin acquisition; sampled in IDLE only.
REQ-007 SHALL have port: abort  in  1  terminate acquisition; highest priority.
REQ-008 SHALL have port: sync_mode  in  2  00 immediate, 01 wait index, 10 wait track mark, 11 = 00.
REQ-009 SHALL have port: stop_idx  in  6  index pulses before auto-stop; 0 = no index stop.
REQ-010 SHALL have port: mem_full  in  1  capture memory full.
REQ-011 SHALL have port: mdat_out  out  8  sample byte, valid while mwrite=1.
REQ-012 SHALL have port: mwrite  out  1  one-cycle memory write strobe.
REQ-013 SHALL have port: maddr_inc  out  1  one-cycle memory address increment, cycle after mwrite.
REQ-014 SHALL have port: running  out  1  1 whenever state != IDLE.
REQ-015 SHALL have port: overflow  out  1  sticky; acquisition ended by mem_full.

Function
REQ-016 SHALL synchronise rddata through 3 flops; flux event = synchronised 1->0 transition (min 2 cycles between events).
REQ-017 SHALL synchronise index through 3 flops; index event = synchronised 0->1 transition.
REQ-018 SHALL implement states IDLE, ARM, ACQ; IDLE->ARM on start=1, latching sync_mode and stop_idx; clear overflow on start.
REQ-019 ARM SHALL go to ACQ on: next cycle (mode 00/11), first index event (01), first trkmark=1 cycle (10); interval counter set to 1, index flag cleared on entry.
REQ-020 In ACQ, 7-bit interval counter SHALL increment each cycle; on flux event write {flag, cnt} and load cnt=1.
REQ-021 If cnt==127 and no flux event, SHALL write {flag, 7'h00} (carry, decoder adds 127) and load cnt=1; flux at cnt==127 writes 7'h7F.
REQ-022 Index flag SHALL set on index event in ACQ, clear on every write; index event coincident with write SHALL be ORed into that byte.
REQ-023 If stop_idx!=0, a 6-bit counter SHALL decrement per index event in ACQ; on reaching 0, SHALL force a write {1, cnt} that cycle, then go IDLE.
REQ-024 mem_full=1 in ACQ SHALL suppress any write that cycle, set overflow, go IDLE.
REQ-025 abort=1 in ARM/ACQ SHALL go IDLE next edge with no write that cycle; a maddr_inc owed from the prior cycle SHALL still be issued.
REQ-026 start while running SHALL be ignored; sync_mode/stop_idx changes after start SHALL be ignored.
REQ-027 Priority within a cycle: abort > mem_full > stop-count write > flux write > carry write.

Reset
REQ-028 On reset=0: state IDLE, mdat_out=0, mwrite=0, maddr_inc=0, running=0, overflow=0, all counters, flags and synchronisers cleared.
REQ-029 Reset mid-acquisition SHALL drop any pending maddr_inc.

Configuration
REQ-030 Macro DISC_READER_HSTMD_SYNC_EN defined: sync_mode 10 waits for trkmark as REQ-019.
REQ-031 Macro undefined: trkmark ignored, sync_mode 10 behaves as 00, no track-mark logic synthesised.

Verification
REQ-032 mode 00, flux events 40 cycles apart -> bytes 0x28 repeated, each mwrite followed by maddr_inc next cycle.
REQ-033 Single flux event 200 cycles after ACQ entry -> bytes 0x00 then 0x49.
REQ-034 mode 01, stop_idx=2, flux every 50 cycles, two index pulses -> no writes before first index; second index forces byte with bit7=1, running drops.
REQ-035 mem_full asserted mid-ACQ -> no further mwrite, overflow=1, running=0; next start clears overflow.
REQ-036 abort coincident with flux event -> no mwrite that cycle, IDLE next edge; reset=0 mid-ACQ -> all outputs 0 immediately.
